// File: rtl/lpffir_pkg.sv
// rtl/lpffir_pkg.sv - width helpers, coefficient write bundle and round/saturate function for lpffir_pipe
package lpffir_pkg;

  localparam int SR_W       = 64;
  localparam int ADDR_MAX_W = 5;
  localparam int COEF_MAX_W = 32;

  typedef struct packed {
    logic                  we;
    logic [ADDR_MAX_W-1:0] addr;
    logic [COEF_MAX_W-1:0] data;
  } coef_wr_t;

  function automatic int tree_depth(input int taps);
    return $clog2(taps);
  endfunction

  function automatic int acc_w(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

  // Returns {ovf, y}; y is the round-half-up, saturated result sign-extended to SR_W bits.
  function automatic logic [SR_W:0] sat_round(input logic signed [SR_W-1:0] acc,
                                              input int frac, input int dw);
    logic signed [SR_W-1:0] r;
    logic signed [SR_W-1:0] hi;
    logic signed [SR_W-1:0] lo;
    logic                   ovf;
    r = acc;
    if (frac > 0) begin
      r = r + (64'sd1 <<< (frac - 1));
    end
    r   = r >>> frac;
    hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (dw - 1));
    ovf = 1'b0;
    if (r > hi) begin
      r   = hi;
      ovf = 1'b1;
    end else if (r < lo) begin
      r   = lo;
      ovf = 1'b1;
    end
    return {ovf, r};
  endfunction

endpackage

// File: rtl/lpffir_add_tree.sv
// rtl/lpffir_add_tree.sv - registered pairwise adder tree with enable and valid pipeline
module lpffir_add_tree
  import lpffir_pkg::*;
#(
  parameter int N     = 6,
  parameter int W     = 32,
  parameter int AW    = 35,
  parameter int DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 din_valid,
  input  logic [N-1:0][W-1:0]  din,
  output logic                 sum_valid,
  output logic signed [AW-1:0] sum
);

  logic signed [AW-1:0] lvl_q [DEPTH][N];
  logic signed [AW-1:0] opnd  [DEPTH][2*N];
  logic [DEPTH-1:0]     v_q;

  // Operand slots past the live count stay zero, so odd operands pass through unchanged.
  always_comb begin
    for (int l = 0; l < DEPTH; l++) begin
      for (int i = 0; i < 2 * N; i++) begin
        opnd[l][i] = '0;
      end
    end
    for (int i = 0; i < N; i++) begin
      opnd[0][i] = AW'(signed'(din[i]));
      for (int l = 1; l < DEPTH; l++) begin
        opnd[l][i] = lvl_q[l-1][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < DEPTH; l++) begin
        for (int i = 0; i < N; i++) begin
          lvl_q[l][i] <= '0;
        end
      end
      v_q <= '0;
    end else if (en) begin
      for (int l = 0; l < DEPTH; l++) begin
        for (int i = 0; i < N; i++) begin
          lvl_q[l][i] <= opnd[l][2*i] + opnd[l][2*i+1];
        end
      end
      v_q[0] <= din_valid;
      for (int l = 1; l < DEPTH; l++) begin
        v_q[l] <= v_q[l-1];
      end
    end
  end

  assign sum       = lvl_q[DEPTH-1][0];
  assign sum_valid = v_q[DEPTH-1];

endmodule

// File: rtl/lpffir_pipe.sv
// rtl/lpffir_pipe.sv - pipelined low-pass FIR with programmable coefficients, rounding and saturation
module lpffir_pipe
  import lpffir_pkg::*;
#(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int TAPS = 6,
  parameter int FRAC = 0,
  parameter int CRST = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     x_valid_i,
  input  logic signed [DW-1:0]     x_i,
  input  logic                     coef_we_i,
  input  logic [$clog2(TAPS)-1:0]  coef_addr_i,
  input  logic signed [CW-1:0]     coef_data_i,
  output logic                     y_valid_o,
  output logic signed [DW-1:0]     y_o,
  output logic                     ovf_o
);

  localparam int AB    = $clog2(TAPS);
  localparam int PW    = DW + CW;
  localparam int AW    = acc_w(DW, CW, TAPS);
  localparam int DEPTH = tree_depth(TAPS);

  coef_wr_t                wr;
  logic signed [CW-1:0]    c_q [TAPS];
  logic signed [DW-1:0]    d_q [TAPS];
  logic                    d_v_q;
  logic [TAPS-1:0][PW-1:0] p_q;
  logic                    p_v_q;
  logic signed [AW-1:0]    t_sum;
  logic                    t_v;
  logic [SR_W:0]           sr;
  logic                    y_v_q;
  logic signed [DW-1:0]    y_q;
  logic                    ovf_q;
  logic                    unused_bits;

  assign wr = '{we: coef_we_i, addr: ADDR_MAX_W'(coef_addr_i), data: COEF_MAX_W'(coef_data_i)};

  // Coefficient bank ignores en_i; reset takes priority over a coincident write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < TAPS; k++) begin
        c_q[k] <= CW'(CRST);
      end
    end else if (wr.we && (int'(wr.addr) < TAPS)) begin
      c_q[wr.addr[AB-1:0]] <= wr.data[CW-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < TAPS; k++) begin
        d_q[k] <= '0;
      end
      d_v_q <= 1'b0;
    end else if (en_i) begin
      d_v_q <= x_valid_i;
      if (x_valid_i) begin
        d_q[0] <= x_i;
        for (int k = 1; k < TAPS; k++) begin
          d_q[k] <= d_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_q   <= '0;
      p_v_q <= 1'b0;
    end else if (en_i) begin
      p_v_q <= d_v_q;
      for (int k = 0; k < TAPS; k++) begin
        p_q[k] <= PW'(d_q[k]) * PW'(c_q[k]);
      end
    end
  end

  lpffir_add_tree #(
    .N     (TAPS),
    .W     (PW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_tree (
    .clk       (clk_i),
    .rst       (rst_i),
    .en        (en_i),
    .din_valid (p_v_q),
    .din       (p_q),
    .sum_valid (t_v),
    .sum       (t_sum)
  );

  assign sr = sat_round(SR_W'(t_sum), FRAC, DW);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      y_v_q <= 1'b0;
      y_q   <= '0;
      ovf_q <= 1'b0;
    end else if (en_i) begin
      y_v_q <= t_v;
      y_q   <= sr[DW-1:0];
      ovf_q <= sr[SR_W];
    end
  end

  // A held result is only presented on an enabled cycle, so each sample appears exactly once.
  assign y_valid_o = y_v_q & en_i;
  assign y_o       = y_q;
  assign ovf_o     = ovf_q;

  assign unused_bits = ^{sr >> DW, wr.data >> CW};

endmodule
